// File: rtl/error_tracker_if.sv
// error_tracker_if: frame input and capture read-out bundle for error_tracker
interface error_tracker_if #(
    parameter int WIDTH          = 16,
    parameter int ERROR_BITWIDTH = 8,
    parameter int TS_BITWIDTH    = 16,
    parameter int FIFO_DEPTH     = 8
);
    logic [WIDTH-1:0][ERROR_BITWIDTH-1:0] i_est_errors;
    logic [WIDTH-1:0]                     i_sliced_bits;
    logic [WIDTH-1:0][1:0]                i_sd_flags;
    logic [ERROR_BITWIDTH-1:0]            i_err_thresh;
    logic [1:0]                           i_trig_mode;
    logic [3:0]                           i_post_frames;
    logic                                 i_arm;
    logic                                 i_rd_en;
    logic                                 o_rd_valid;
    logic [WIDTH-1:0][ERROR_BITWIDTH-1:0] o_rd_errors;
    logic [WIDTH-1:0]                     o_rd_bits;
    logic [WIDTH-1:0][1:0]                o_rd_flags;
    logic [TS_BITWIDTH-1:0]               o_rd_timestamp;
    logic                                 o_rd_trigger;
    logic [$clog2(FIFO_DEPTH):0]          o_count;
    logic                                 o_full;
    logic                                 o_overflow;
    logic [1:0]                           o_state;

    modport master (
        output i_est_errors, i_sliced_bits, i_sd_flags, i_err_thresh, i_trig_mode,
               i_post_frames, i_arm, i_rd_en,
        input  o_rd_valid, o_rd_errors, o_rd_bits, o_rd_flags, o_rd_timestamp,
               o_rd_trigger, o_count, o_full, o_overflow, o_state
    );

    modport slave (
        input  i_est_errors, i_sliced_bits, i_sd_flags, i_err_thresh, i_trig_mode,
               i_post_frames, i_arm, i_rd_en,
        output o_rd_valid, o_rd_errors, o_rd_bits, o_rd_flags, o_rd_timestamp,
               o_rd_trigger, o_count, o_full, o_overflow, o_state
    );
endinterface

// File: rtl/error_tracker.sv
// error_tracker: triggered capture of datapath frames into a FWFT FIFO; ERR_TRACK_CONT_EN re-arms after each capture
module error_tracker #(
    parameter int WIDTH          = 16,
    parameter int ERROR_BITWIDTH = 8,
    parameter int TS_BITWIDTH    = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input logic            clk,
    input logic            rst,
    error_tracker_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EB = ERROR_BITWIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
`ifdef ERR_TRACK_CONT_EN
    localparam logic [1:0] S_DONE  = S_ARMED;
`else
    localparam logic [1:0] S_DONE  = S_IDLE;
`endif

    logic [WIDTH-1:0][EB-1:0]   r_err;
    logic [WIDTH-1:0]           r_bits;
    logic [WIDTH-1:0][1:0]      r_flags;
    logic [EB-1:0]              r_thresh;
    logic [1:0]                 r_mode;
    logic [TS_BITWIDTH-1:0]     r_ts;
    logic [TS_BITWIDTH-1:0]     r_fts;
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nx;
    logic [3:0]                 r_post;
    logic [EB:0]                w_mag;
    logic                       w_err_hit;
    logic                       w_trig;
    logic                       w_wr;
    logic                       w_wr_trig;

    logic [WIDTH-1:0][EB-1:0]   r_mem_err   [FIFO_DEPTH];
    logic [WIDTH-1:0]           r_mem_bits  [FIFO_DEPTH];
    logic [WIDTH-1:0][1:0]      r_mem_flags [FIFO_DEPTH];
    logic [TS_BITWIDTH-1:0]     r_mem_ts    [FIFO_DEPTH];
    logic                       r_mem_trig  [FIFO_DEPTH];
    logic [AW-1:0]              r_wp;
    logic [AW-1:0]              r_rp;
    logic [CW-1:0]              r_cnt;
    logic                       r_ovf;
    logic                       w_valid;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;

    // register each frame with the timestamp current at its capture edge and its trigger settings
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err    <= '0;
            r_bits   <= '0;
            r_flags  <= '0;
            r_thresh <= '0;
            r_mode   <= '0;
            r_fts    <= '0;
            r_ts     <= '0;
        end else begin
            r_err    <= bus.i_est_errors;
            r_bits   <= bus.i_sliced_bits;
            r_flags  <= bus.i_sd_flags;
            r_thresh <= bus.i_err_thresh;
            r_mode   <= bus.i_trig_mode;
            r_fts    <= r_ts;
            r_ts     <= r_ts + 1'b1;
        end
    end

    // any lane magnitude strictly above threshold; one extra bit keeps the most negative value exact
    always_comb begin
        w_err_hit = 1'b0;
        w_mag     = '0;
        for (int l = 0; l < WIDTH; l++) begin
            w_mag     = r_err[l][EB-1] ? -{1'b1, r_err[l]} : {1'b0, r_err[l]};
            w_err_hit = w_err_hit | (w_mag > {1'b0, r_thresh});
        end
        w_trig = (r_mode[0] & (|r_flags)) | (r_mode[1] & w_err_hit);
    end

    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_state_nx;
    end

    // next-state decode
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = bus.i_arm ? S_ARMED : S_IDLE;
            S_ARMED: w_state_nx = !w_trig ? S_ARMED : (bus.i_post_frames == 4'd0) ? S_DONE : S_POST;
            S_POST:  w_state_nx = (r_post == 4'd1) ? S_DONE : S_POST;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // capture write strobes
    always_comb begin
        w_wr      = (r_state == S_ARMED && w_trig) || r_state == S_POST;
        w_wr_trig = r_state == S_ARMED;
    end

    // post-trigger frame counter, loaded at trigger and counted down on every post write
    always_ff @(posedge clk) begin
        if (rst)
            r_post <= '0;
        else if (r_state == S_ARMED && w_trig)
            r_post <= bus.i_post_frames;
        else if (r_state == S_POST)
            r_post <= r_post - 1'b1;
    end

    assign w_valid = r_cnt != '0;
    assign w_full  = r_cnt == CW'(FIFO_DEPTH);
    assign w_pop   = bus.i_rd_en && w_valid;
    assign w_push  = w_wr && (!w_full || w_pop);

    // storage array; outputs are gated so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_err[r_wp]   <= r_err;
            r_mem_bits[r_wp]  <= r_bits;
            r_mem_flags[r_wp] <= r_flags;
            r_mem_ts[r_wp]    <= r_fts;
            r_mem_trig[r_wp]  <= w_wr_trig;
        end
    end

    // pointers, occupancy and sticky overflow; a pop on a full FIFO makes room for the same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_wr && !w_push)
                r_ovf <= 1'b1;
        end
    end

    assign bus.o_rd_valid     = w_valid;
    assign bus.o_rd_errors    = w_valid ? r_mem_err[r_rp]   : '0;
    assign bus.o_rd_bits      = w_valid ? r_mem_bits[r_rp]  : '0;
    assign bus.o_rd_flags     = w_valid ? r_mem_flags[r_rp] : '0;
    assign bus.o_rd_timestamp = w_valid ? r_mem_ts[r_rp]    : '0;
    assign bus.o_rd_trigger   = w_valid ? r_mem_trig[r_rp]  : 1'b0;
    assign bus.o_count        = r_cnt;
    assign bus.o_full         = w_full;
    assign bus.o_overflow     = r_ovf;
    assign bus.o_state        = r_state;
endmodule

// File: tb/tb_error_tracker.sv
// tb_error_tracker: directed checks of trigger modes, post capture, FIFO overflow, reset abort and re-arm behaviour
module tb_error_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int edges = 0;
    int t0 = 0;

    error_tracker_if bus ();
    error_tracker dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // reference timestamp: number of non-reset edges so far equals the stamp of the next registered frame
    always @(posedge clk) edges <= rst ? 0 : edges + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [127:0] lane_e(input int l, input logic [7:0] v);
        logic [127:0] r;
        r = '0;
        r[l*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [31:0] lane_f(input int l, input logic [1:0] v);
        logic [31:0] r;
        r = '0;
        r[l*2 +: 2] = v;
        return r;
    endfunction

    task automatic frame(input logic [127:0] e, input logic [31:0] f, input logic [15:0] b);
        bus.i_est_errors  = e;
        bus.i_sd_flags    = f;
        bus.i_sliced_bits = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame('0, '0, '0);
        bus.i_arm = 1'b0;
        bus.i_rd_en = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic arm_it(input logic [1:0] mode, input logic [3:0] post, input logic [7:0] th);
        bus.i_trig_mode = mode;
        bus.i_post_frames = post;
        bus.i_err_thresh = th;
        bus.i_arm = 1'b1;
        tick(1);
        bus.i_arm = 1'b0;
        tick(1);
    endtask

    task automatic pop(input string tag, input logic trig, input int ts,
                       input logic [127:0] e, input logic [31:0] f, input logic [15:0] b);
        chk({tag, ".valid"}, 128'(bus.o_rd_valid), 128'(1'b1));
        chk({tag, ".trig"}, 128'(bus.o_rd_trigger), 128'(trig));
        chk({tag, ".ts"}, 128'(bus.o_rd_timestamp), 128'(16'(ts)));
        chk({tag, ".err"}, 128'(bus.o_rd_errors), e);
        chk({tag, ".flags"}, 128'(bus.o_rd_flags), 128'(f));
        chk({tag, ".bits"}, 128'(bus.o_rd_bits), 128'(b));
        bus.i_rd_en = 1'b1;
        tick(1);
        bus.i_rd_en = 1'b0;
    endtask

    initial begin
        bus.i_trig_mode = 2'd0;
        bus.i_post_frames = 4'd0;
        bus.i_err_thresh = 8'd0;
        do_reset();
        chk("rst.state", 128'(bus.o_state), 128'(2'd0));
        chk("rst.count", 128'(bus.o_count), 128'(4'd0));
        chk("rst.valid", 128'(bus.o_rd_valid), 128'(1'b0));
        chk("rst.full", 128'(bus.o_full), 128'(1'b0));
        chk("rst.ovf", 128'(bus.o_overflow), 128'(1'b0));
        chk("rst.ts", 128'(bus.o_rd_timestamp), 128'(16'd0));
        chk("rst.err", 128'(bus.o_rd_errors), 128'(0));
        bus.i_rd_en = 1'b1;
        tick(1);
        bus.i_rd_en = 1'b0;
        chk("empty_pop.count", 128'(bus.o_count), 128'(4'd0));

        // flag trigger with two post frames
        arm_it(2'd1, 4'd2, 8'd0);
        chk("t1.armed", 128'(bus.o_state), 128'(2'd1));
        tick(2);
        chk("t1.quiet", 128'(bus.o_count), 128'(4'd0));
        t0 = edges;
        frame('0, lane_f(3, 2'b01), 16'h0008);
        tick(1);
        frame('0, '0, '0);
        tick(1);
        chk("t1.post", 128'(bus.o_state), 128'(2'd2));
        tick(2);
        chk("t1.count", 128'(bus.o_count), 128'(4'd3));
        chk("t1.idle", 128'(bus.o_state), 128'(2'd0));
        pop("t1.e0", 1'b1, t0, '0, lane_f(3, 2'b01), 16'h0008);
        pop("t1.e1", 1'b0, t0 + 1, '0, '0, '0);
        pop("t1.e2", 1'b0, t0 + 2, '0, '0, '0);
        chk("t1.empty", 128'(bus.o_rd_valid), 128'(1'b0));

        // magnitude trigger: equal to threshold does not fire, one above does
        arm_it(2'd2, 4'd0, 8'd20);
        frame(lane_e(0, 8'd20), '0, '0);
        tick(1);
        t0 = edges;
        frame(lane_e(5, 8'hEB), '0, '0);
        tick(1);
        frame('0, '0, '0);
        tick(1);
        chk("t2.count", 128'(bus.o_count), 128'(4'd1));
        chk("t2.idle", 128'(bus.o_state), 128'(2'd0));
        pop("t2.e0", 1'b1, t0, lane_e(5, 8'hEB), '0, '0);
        arm_it(2'd2, 4'd0, 8'd127);
        frame(lane_e(1, 8'd127), '0, '0);
        tick(1);
        t0 = edges;
        frame(lane_e(2, 8'h80), '0, '0);
        tick(1);
        frame('0, '0, '0);
        tick(1);
        chk("t2b.count", 128'(bus.o_count), 128'(4'd1));
        pop("t2b.e0", 1'b1, t0, lane_e(2, 8'h80), '0, '0);

        // sixteen frames into eight slots, no reads
        do_reset();
        arm_it(2'd1, 4'd15, 8'd0);
        t0 = edges;
        for (int i = 0; i < 16; i++) begin
            frame(lane_e(0, 8'(i)), (i == 0) ? lane_f(0, 2'b10) : '0, 16'(i));
            tick(1);
        end
        chk("t3.still_post", 128'(bus.o_state), 128'(2'd2));
        frame('0, '0, '0);
        tick(1);
        chk("t3.count", 128'(bus.o_count), 128'(4'd8));
        chk("t3.full", 128'(bus.o_full), 128'(1'b1));
        chk("t3.ovf", 128'(bus.o_overflow), 128'(1'b1));
        chk("t3.idle", 128'(bus.o_state), 128'(2'd0));
        for (int j = 0; j < 8; j++)
            pop($sformatf("t3.e%0d", j), j == 0, t0 + j, lane_e(0, 8'(j)),
                (j == 0) ? lane_f(0, 2'b10) : '0, 16'(j));
        chk("t3.drained", 128'(bus.o_count), 128'(4'd0));
        chk("t3.ovf_sticky", 128'(bus.o_overflow), 128'(1'b1));

        // pop and post write together on a full FIFO
        do_reset();
        arm_it(2'd1, 4'd15, 8'd0);
        t0 = edges;
        for (int i = 0; i < 16; i++) begin
            frame(lane_e(0, 8'(i)), (i == 0) ? lane_f(0, 2'b10) : '0, 16'(i));
            if (i == 9) begin
                chk("t4.pre_count", 128'(bus.o_count), 128'(4'd8));
                chk("t4.pre_ovf", 128'(bus.o_overflow), 128'(1'b0));
            end
            bus.i_rd_en = (i == 9);
            tick(1);
            if (i == 9) begin
                chk("t4.count", 128'(bus.o_count), 128'(4'd8));
                chk("t4.ovf", 128'(bus.o_overflow), 128'(1'b0));
                chk("t4.head", 128'(bus.o_rd_errors), lane_e(0, 8'd1));
            end
        end
        bus.i_rd_en = 1'b0;
        frame('0, '0, '0);
        tick(1);
        chk("t4.ovf_late", 128'(bus.o_overflow), 128'(1'b1));
        chk("t4.idle", 128'(bus.o_state), 128'(2'd0));
        for (int j = 0; j < 8; j++)
            pop($sformatf("t4.e%0d", j), 1'b0, t0 + 1 + j, lane_e(0, 8'(j + 1)), '0, 16'(j + 1));

        // reset during POST
        do_reset();
        arm_it(2'd1, 4'd15, 8'd0);
        frame('0, lane_f(7, 2'b01), '0);
        tick(1);
        frame('0, '0, '0);
        tick(3);
        chk("t5.count", 128'(bus.o_count), 128'(4'd3));
        chk("t5.post", 128'(bus.o_state), 128'(2'd2));
        rst = 1'b1;
        tick(1);
        chk("t5.state", 128'(bus.o_state), 128'(2'd0));
        chk("t5.cnt", 128'(bus.o_count), 128'(4'd0));
        chk("t5.valid", 128'(bus.o_rd_valid), 128'(1'b0));
        chk("t5.ts", 128'(bus.o_rd_timestamp), 128'(16'd0));
        rst = 1'b0;

        // two captures five cycles apart after a single arm
        arm_it(2'd1, 4'd1, 8'd0);
        t0 = edges;
        frame('0, lane_f(0, 2'b01), '0);
        tick(1);
        frame('0, '0, '0);
        tick(4);
        frame('0, lane_f(0, 2'b01), '0);
        tick(1);
        frame('0, '0, '0);
        tick(4);
`ifdef ERR_TRACK_CONT_EN
        chk("t6.count", 128'(bus.o_count), 128'(4'd4));
        chk("t6.state", 128'(bus.o_state), 128'(2'd1));
`else
        chk("t6.count", 128'(bus.o_count), 128'(4'd2));
        chk("t6.state", 128'(bus.o_state), 128'(2'd0));
`endif
        pop("t6.e0", 1'b1, t0, '0, lane_f(0, 2'b01), '0);
        pop("t6.e1", 1'b0, t0 + 1, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
